multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle variant of the CPU. It sequences one shared ALU, one unified instruction/data memory port and the register file across several cycles per instruction. It supports the same instruction set as the single-cycle decoder: ADD, ADDI, ADDIU, LUI, LW, SW, BEQ and J. It sits between the instruction register (opcode/funcode) and the datapath muxes and enables. Memory accesses use a req/ready handshake with a timeout.

Parameters:
TIMEOUT, 15, maximum number of cycles mem_req may stay high without mem_ready before bus_err is raised; legal range 1..255.
ALU_W, 3, width of alu_control.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset; synchronous and active-high.
opcode  in  6  IR[31:26].
funcode  in  6  IR[5:0].
zero  in  1  ALU zero flag.
mem_ready  in  1  memory has completed the current request this cycle.
mem_req  out  1  memory request; held high until mem_ready.
mem_write  out  1  request is a write (valid only with mem_req).
iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
ir_write  out  1  load the IR.
pc_write  out  1  load the PC.
pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
reg_write  out  1  register-file write enable.
wa_control  out  1  write-address select: 0 = rt, 1 = rd.
wd_control  out  1  write-data select: 0 = ALUOut, 1 = MDR.
alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A.
alu_src_b  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
alu_control  out  ALU_W  ALU operation: 000 = ADD, 001 = SUB, 010 = PASS_B, 111 = NONE.
sign_ext_signal  out  2  extender mode: 00 = none, 01 = sign-extend, 10 = LUI (imm << 16).
illegal  out  1  sticky flag: unsupported opcode or funcode.
bus_err  out  1  sticky flag: memory timeout.
state_o  out  4  current state, for debug.

Behaviour:
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
  - REX = 6, RWB = 7, IEX = 8, IWB = 9, BR = 10, JMP = 11, TRAP = 15.
- Outputs are Moore from the state register, except ir_write, pc_write and the FETCH exit, which are qualified by mem_ready or zero as noted below.
- Default for any signal not listed for a state: 0, and alu_control = NONE.
- rst = 1 takes effect at the next clock edge, from any state and even mid-transaction:
  - state becomes FETCH; illegal, bus_err and the timeout counter clear.
  - The first post-reset cycle therefore drives mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_control = ADD; all other outputs are 0.
- FETCH:
  - Drives mem_req = 1, iord = 0, and the PC + 4 setup (alu_src_a = 0, alu_src_b = 01, ADD).
  - When mem_ready = 1: ir_write = 1 and pc_write = 1 (pc_src = 00) in that same cycle, and next state is DECODE. Otherwise stay in FETCH.
- DECODE:
  - Drives alu_src_a = 0, alu_src_b = 11, ADD, sign_ext_signal = 01 (precomputes the branch target).
  - Dispatch on the next edge:
    - LW or SW → MEMADR.
    - opcode 000000 with funcode 100000 → REX.
    - ADDI, ADDIU or LUI → IEX.
    - BEQ → BR.
    - J → JMP.
    - Anything else → TRAP with illegal set.
- MEMADR: alu_src_a = 1, alu_src_b = 10, ADD, sign_ext_signal = 01. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req = 1, iord = 1. Go to MEMWB on mem_ready.
- MEMWB: reg_write = 1, wa_control = 0, wd_control = 1. Next state FETCH.
- MEMWR: mem_req = 1, mem_write = 1, iord = 1. Go to FETCH on mem_ready.
- REX: alu_src_a = 1, alu_src_b = 00, ADD. Next state RWB.
- RWB: reg_write = 1, wa_control = 1, wd_control = 0. Next state FETCH.
- IEX:
  - alu_src_a = 1, alu_src_b = 10.
  - ADDI/ADDIU: ADD with sign_ext_signal = 01.
  - LUI: PASS_B with sign_ext_signal = 10.
  - Next state IWB.
- IWB: reg_write = 1, wa_control = 0, wd_control = 0. Next state FETCH.
- BR: alu_src_a = 1, alu_src_b = 00, SUB. pc_src = 01 and pc_write = zero. Next state FETCH.
- JMP: pc_write = 1, pc_src = 10. Next state FETCH.
- TRAP:
  - All enables are 0 and the state holds until rst.
  - illegal or bus_err stays high.
- Opcode and funcode are sampled only in DECODE, MEMADR and IEX. The IR is stable after FETCH.
- Latency with zero-wait memory:
  - LW: 5 cycles. SW, R-type, ADDI/ADDIU/LUI: 4 cycles. BEQ, J: 3 cycles.
  - Each memory wait cycle adds 1.
- Timeout:
  - An 8-bit counter clears on entry to FETCH, MEMRD or MEMWR, and increments each cycle that mem_req = 1 and mem_ready = 0.
  - If the counter reaches TIMEOUT with mem_ready still 0, the next state is TRAP and bus_err is set.
  - mem_ready = 1 in the same cycle the counter reaches TIMEOUT counts as success (ready wins).
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

Test Plan:
1. Reset, then ADD (opcode 0, funcode 0x20) with mem_ready tied 1 → states 0,1,6,7,0. reg_write = 1 and wa_control = 1 only in state 7. pc_write is pulsed only in cycle 0.
2. LW (0x23) with mem_ready delayed 3 cycles in MEMRD → states 0,1,2,3,3,3,3,4,0. wd_control = 1 in MEMWB. mem_req is held high throughout MEMRD.
3. BEQ (0x04) with zero = 1, then zero = 0 → pc_write = 1 with pc_src = 01 in BR for the first; pc_write = 0 for the second. Both return to FETCH after 3 cycles.
4. LUI (0x0F) → in IEX, sign_ext_signal = 10 and alu_control = 010. SW (0x2B) → mem_write = 1 only in MEMWR, with reg_write never asserted.
5. Opcode 0x3F, and opcode 0 with funcode 0x22 → TRAP after DECODE with illegal = 1, held for 10 cycles. rst = 1 then returns to FETCH and illegal = 0.
6. TIMEOUT = 15 with mem_ready held 0 in FETCH → bus_err = 1 and state 15 after 15 waiting cycles. Repeat with mem_ready = 1 on the 15th cycle → DECODE with no error. Assert rst in the middle of MEMWR → FETCH with mem_write = 0 on the next cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle CPU. It sequences one shared ALU, a unified
// req/ready memory port and the register file across several cycles per instruction.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned ALU_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             wa_control,
  output logic             wd_control,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [ALU_W-1:0] alu_control,
  output logic [1:0]       sign_ext_signal,
  output logic             illegal,
  output logic             bus_err,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    IEX    = 4'd8,
    IWB    = 4'd9,
    BR     = 4'd10,
    JMP    = 4'd11,
    TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;

  localparam logic [ALU_W-1:0] ALU_ADD    = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB    = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_PASS_B = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_NONE   = {ALU_W{1'b1}};

  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_IMMSH = 2'b11;

  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // Last count value still allowed to wait; one more miss means timeout.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef struct packed {
    logic             mem_req;
    logic             mem_write;
    logic             iord;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic             wa_control;
    logic             wd_control;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [ALU_W-1:0] alu_control;
    logic [1:0]       sign_ext_signal;
  } ctrl_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic       set_illegal;
  logic       set_bus_err;
  ctrl_t      ctrl;

  logic is_lw, is_sw, is_add, is_imm, is_beq, is_j;

  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_add = (opcode == OP_RTYPE) && (funcode == FN_ADD);
  assign is_imm = (opcode == OP_ADDI) || (opcode == OP_ADDIU) || (opcode == OP_LUI);
  assign is_beq = (opcode == OP_BEQ);
  assign is_j   = (opcode == OP_J);

  // Moore control word for a given state; IEX is the only state that also looks at the opcode.
  function automatic ctrl_t moore_outs(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    c.alu_control = ALU_NONE;
    case (s)
      FETCH: begin
        c.mem_req     = 1'b1;
        c.alu_src_b   = SRC_B_FOUR;
        c.alu_control = ALU_ADD;
      end
      DECODE: begin
        c.alu_src_b       = SRC_B_IMMSH;
        c.alu_control     = ALU_ADD;
        c.sign_ext_signal = EXT_SIGN;
      end
      MEMADR: begin
        c.alu_src_a       = 1'b1;
        c.alu_src_b       = SRC_B_IMM;
        c.alu_control     = ALU_ADD;
        c.sign_ext_signal = EXT_SIGN;
      end
      MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.wd_control = 1'b1;
      end
      MEMWR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      REX: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRC_B_REG;
        c.alu_control = ALU_ADD;
      end
      RWB: begin
        c.reg_write  = 1'b1;
        c.wa_control = 1'b1;
      end
      IEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
        if (op == OP_LUI) begin
          c.alu_control     = ALU_PASS_B;
          c.sign_ext_signal = EXT_LUI;
        end else begin
          c.alu_control     = ALU_ADD;
          c.sign_ext_signal = EXT_SIGN;
        end
      end
      IWB: c.reg_write = 1'b1;
      BR: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRC_B_REG;
        c.alu_control = ALU_SUB;
        c.pc_src      = 2'b01;
      end
      JMP:     c.pc_src = 2'b10;
      default: ;
    endcase
    return c;
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state)
      FETCH, MEMRD, MEMWR: begin
        if (mem_ready) begin
          case (state)
            FETCH:   state_next = DECODE;
            MEMRD:   state_next = MEMWB;
            default: state_next = FETCH;
          endcase
        end else if (cnt == CNT_LAST) begin
          state_next  = TRAP;
          set_bus_err = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      DECODE: begin
        if (is_lw || is_sw) begin
          state_next = MEMADR;
        end else if (is_add) begin
          state_next = REX;
        end else if (is_imm) begin
          state_next = IEX;
        end else if (is_beq) begin
          state_next = BR;
        end else if (is_j) begin
          state_next = JMP;
        end else begin
          state_next  = TRAP;
          set_illegal = 1'b1;
        end
      end
      MEMADR:                  state_next = is_sw ? MEMWR : MEMRD;
      REX:                     state_next = RWB;
      IEX:                     state_next = IWB;
      MEMWB, RWB, IWB, BR, JMP: state_next = FETCH;
      default:                 state_next = TRAP;
    endcase
    // The wait counter restarts whenever a memory-waiting state is newly entered.
    if ((state_next != state) && (state_next inside {FETCH, MEMRD, MEMWR})) begin
      cnt_next = '0;
    end
  end

  // NOTE: the control word is registered from the next state, so it lines up with the state register
  // it belongs to and reaches the datapath straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      cnt     <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      ctrl    <= moore_outs(FETCH, opcode);
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      illegal <= illegal | set_illegal;
      bus_err <= bus_err | set_bus_err;
      ctrl    <= moore_outs(state_next, opcode);
    end
  end

  assign mem_req         = ctrl.mem_req;
  assign mem_write       = ctrl.mem_write;
  assign iord            = ctrl.iord;
  assign pc_src          = ctrl.pc_src;
  assign reg_write       = ctrl.reg_write;
  assign wa_control      = ctrl.wa_control;
  assign wd_control      = ctrl.wd_control;
  assign alu_src_a       = ctrl.alu_src_a;
  assign alu_src_b       = ctrl.alu_src_b;
  assign alu_control     = ctrl.alu_control;
  assign sign_ext_signal = ctrl.sign_ext_signal;
  assign state_o         = state;

  // IR and PC loads complete in the same cycle the fetch is acknowledged.
  assign ir_write = (state == FETCH) && mem_ready;
  assign pc_write = ((state == FETCH) && mem_ready) || ((state == BR) && zero) || (state == JMP);

  mem_write_has_req: assert property (@(posedge clk) disable iff (rst) mem_write |-> mem_req);
  cnt_in_range:      assert property (@(posedge clk) disable iff (rst) cnt <= CNT_LAST);
  flags_only_trap:   assert property (@(posedge clk) disable iff (rst) (illegal || bus_err) |-> (state == TRAP));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected traces are expanded from
// instruction class, memory wait counts and the timeout rule, then compared cycle by cycle.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 15;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, wa_control, wd_control, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] sign_ext_signal;
  logic       illegal, bus_err;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .ALU_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funcode(funcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .wa_control(wa_control), .wd_control(wd_control), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .sign_ext_signal(sign_ext_signal),
    .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
  );

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       zr;
    logic       ill;
    logic       berr;
  } step_t;

  step_t       exp_q[$];
  logic [23:0] act_q[$];
  logic [23:0] exv_q[$];
  logic [5:0]  cur_op, cur_fn;
  logic        m_ill, m_berr;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [23:0] snap();
    return {mem_req, mem_write, iord, ir_write, pc_write, pc_src, reg_write, wa_control,
            wd_control, alu_src_a, alu_src_b, alu_control, sign_ext_signal, illegal, bus_err, state_o};
  endfunction

  // Output table per state, straight from the control-signal description of each state.
  function automatic logic [23:0] expect_vec(input step_t s, input logic [5:0] op);
    logic mreq, mwr, io, irw, pcw, rw, wa, wd, sa;
    logic [1:0] pcs, sb, se;
    logic [2:0] alu;
    {mreq, mwr, io, irw, pcw, rw, wa, wd, sa} = '0;
    pcs = 2'b00; sb = 2'b00; se = 2'b00; alu = 3'b111;
    case (s.st)
      4'd0:  begin mreq = 1; sb = 2'b01; alu = 3'b000; irw = s.rdy; pcw = s.rdy; end
      4'd1:  begin sb = 2'b11; alu = 3'b000; se = 2'b01; end
      4'd2:  begin sa = 1; sb = 2'b10; alu = 3'b000; se = 2'b01; end
      4'd3:  begin mreq = 1; io = 1; end
      4'd4:  begin rw = 1; wd = 1; end
      4'd5:  begin mreq = 1; mwr = 1; io = 1; end
      4'd6:  begin sa = 1; alu = 3'b000; end
      4'd7:  begin rw = 1; wa = 1; end
      4'd8:  begin
        sa = 1; sb = 2'b10;
        if (op == OP_LUI) begin alu = 3'b010; se = 2'b10; end
        else begin alu = 3'b000; se = 2'b01; end
      end
      4'd9:  rw = 1;
      4'd10: begin sa = 1; alu = 3'b001; pcs = 2'b01; pcw = s.zr; end
      4'd11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {mreq, mwr, io, irw, pcw, pcs, rw, wa, wd, sa, sb, alu, se, s.ill, s.berr, s.st};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic zr);
    step_t s;
    s.st = st; s.rdy = rdy; s.zr = zr; s.ill = m_ill; s.berr = m_berr;
    exp_q.push_back(s);
  endtask

  task automatic push_free(input logic [3:0] st);
    push(st, 1'($urandom), 1'($urandom));
  endtask

  task automatic mem_phase(input logic [3:0] st, input int wait_n, output bit timed_out);
    if (wait_n >= TIMEOUT) begin
      for (int i = 0; i < TIMEOUT; i++) push(st, 1'b0, 1'($urandom));
      timed_out = 1'b1;
    end else begin
      for (int i = 0; i < wait_n; i++) push(st, 1'b0, 1'($urandom));
      push(st, 1'b1, 1'($urandom));
      timed_out = 1'b0;
    end
  endtask

  task automatic trap_steps(input int n, input bit ill, input bit berr);
    if (ill) m_ill = 1'b1;
    if (berr) m_berr = 1'b1;
    for (int i = 0; i < n; i++) push_free(4'd15);
  endtask

  // Expands one instruction into its expected per-cycle trace.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                       input logic zr, input int trap_n);
    bit to;
    exp_q.delete();
    cur_op = op; cur_fn = fn;
    mem_phase(4'd0, fw, to);
    if (to) begin trap_steps(trap_n, 0, 1); return; end
    push_free(4'd1);
    if (op == OP_LW || op == OP_SW) begin
      push_free(4'd2);
      mem_phase((op == OP_LW) ? 4'd3 : 4'd5, mw, to);
      if (to) begin trap_steps(trap_n, 0, 1); return; end
      if (op == OP_LW) push_free(4'd4);
    end else if (op == OP_R && fn == FN_ADD) begin
      push_free(4'd6); push_free(4'd7);
    end else if (op == OP_ADDI || op == OP_ADDIU || op == OP_LUI) begin
      push_free(4'd8); push_free(4'd9);
    end else if (op == OP_BEQ) begin
      push(4'd10, 1'($urandom), zr);
    end else if (op == OP_J) begin
      push_free(4'd11);
    end else begin
      trap_steps(trap_n, 1, 0);
    end
  endtask

  // Plays the first n expected steps, recording actual and expected vectors; starts and ends on a negedge.
  task automatic run_trace(input int n);
    act_q.delete(); exv_q.delete();
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      opcode = cur_op; funcode = cur_fn;
      mem_ready = exp_q[i].rdy; zero = exp_q[i].zr;
      #1;
      act_q.push_back(snap());
      exv_q.push_back(expect_vec(exp_q[i], cur_op));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0;
    m_ill = 1'b0; m_berr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [23:0] fetch_vec();
    step_t s;
    s.st = 4'd0; s.rdy = 1'b0; s.zr = 1'b0; s.ill = 1'b0; s.berr = 1'b0;
    return expect_vec(s, 6'h00);
  endfunction

  task automatic test_reset();
    logic [23:0] got;
    do_reset();
    mem_ready = 1'b0; zero = 1'b0;
    #1;
    got = snap();
    checks++;
    if (got !== fetch_vec()) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", got, fetch_vec());
    end
  endtask

  task automatic test_add();
    build(OP_R, FN_ADD, 0, 0, 1'b0, 0);
    run_trace(exp_q.size());
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exv_q[i]) begin
        errors++;
        $display("FAIL add step %0d: got %h expected %h", i, act_q[i], exv_q[i]);
      end
    end
  endtask

  task automatic test_lw_wait();
    build(OP_LW, 6'($urandom), 0, 3, 1'b0, 0);
    run_trace(exp_q.size());
    checks++;
    if (act_q.size() != 8) begin
      errors++;
      $display("FAIL lw_length: got %0d expected 8", act_q.size());
    end
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exv_q[i]) begin
        errors++;
        $display("FAIL lw_wait step %0d: got %h expected %h", i, act_q[i], exv_q[i]);
      end
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      build(OP_BEQ, 6'($urandom), 0, 0, 1'(z), 0);
      run_trace(exp_q.size());
      for (int i = 0; i < act_q.size(); i++) begin
        checks++;
        if (act_q[i] !== exv_q[i]) begin
          errors++;
          $display("FAIL beq_zero%0d step %0d: got %h expected %h", z, i, act_q[i], exv_q[i]);
        end
      end
    end
  endtask

  task automatic test_lui_sw();
    build(OP_LUI, 6'($urandom), 0, 0, 1'b0, 0);
    run_trace(exp_q.size());
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exv_q[i]) begin
        errors++;
        $display("FAIL lui step %0d: got %h expected %h", i, act_q[i], exv_q[i]);
      end
    end
    build(OP_SW, 6'($urandom), 1, 2, 1'b0, 0);
    run_trace(exp_q.size());
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exv_q[i]) begin
        errors++;
        $display("FAIL sw step %0d: got %h expected %h", i, act_q[i], exv_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [23:0] got;
    logic [5:0] ops[2];
    logic [5:0] fns[2];
    ops[0] = 6'h3F; fns[0] = 6'h20;
    ops[1] = OP_R;  fns[1] = 6'h22;
    for (int k = 0; k < 2; k++) begin
      build(ops[k], fns[k], 0, 0, 1'b0, 10);
      run_trace(exp_q.size());
      for (int i = 0; i < act_q.size(); i++) begin
        checks++;
        if (act_q[i] !== exv_q[i]) begin
          errors++;
          $display("FAIL illegal%0d step %0d: got %h expected %h", k, i, act_q[i], exv_q[i]);
        end
      end
      do_reset();
      #1;
      got = snap();
      checks++;
      if (got !== fetch_vec()) begin
        errors++;
        $display("FAIL illegal%0d_reset: got %h expected %h", k, got, fetch_vec());
      end
    end
  endtask

  task automatic test_timeout();
    int fw[3];
    int mw[3];
    logic [5:0] op[3];
    fw[0] = TIMEOUT;     mw[0] = 0;       op[0] = OP_R;
    fw[1] = TIMEOUT - 1; mw[1] = 0;       op[1] = OP_R;
    fw[2] = 0;           mw[2] = TIMEOUT; op[2] = OP_LW;
    for (int k = 0; k < 3; k++) begin
      build(op[k], FN_ADD, fw[k], mw[k], 1'b0, 3);
      run_trace(exp_q.size());
      for (int i = 0; i < act_q.size(); i++) begin
        checks++;
        if (act_q[i] !== exv_q[i]) begin
          errors++;
          $display("FAIL timeout%0d step %0d: got %h expected %h", k, i, act_q[i], exv_q[i]);
        end
      end
      if (m_berr) do_reset();
    end
  endtask

  task automatic test_reset_mid_write();
    int k;
    logic [23:0] got;
    build(OP_SW, 6'($urandom), 0, 6, 1'b0, 0);
    k = 0;
    while (k < exp_q.size() && exp_q[k].st != 4'd5) k++;
    run_trace(k + 2);
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exv_q[i]) begin
        errors++;
        $display("FAIL sw_pre_reset step %0d: got %h expected %h", i, act_q[i], exv_q[i]);
      end
    end
    do_reset();
    #1;
    got = snap();
    checks++;
    if (got !== fetch_vec() || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write: got %h expected %h", got, fetch_vec());
    end
  endtask

  task automatic test_random();
    logic [5:0] legal[8];
    logic [5:0] op;
    legal[0] = OP_R;   legal[1] = OP_LW;    legal[2] = OP_SW;    legal[3] = OP_BEQ;
    legal[4] = OP_J;   legal[5] = OP_ADDI;  legal[6] = OP_ADDIU; legal[7] = OP_LUI;
    for (int n = 0; n < 40; n++) begin
      op = legal[$urandom_range(0, 7)];
      build(op, (op == OP_R) ? FN_ADD : 6'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom), 0);
      run_trace(exp_q.size());
      for (int i = 0; i < act_q.size(); i++) begin
        checks++;
        if (act_q[i] !== exv_q[i]) begin
          errors++;
          $display("FAIL random%0d op %h step %0d: got %h expected %h", n, op, i, act_q[i], exv_q[i]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ill = 1'b0; m_berr = 1'b0;
    cur_op = '0; cur_fn = '0;
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_lui_sw();
    test_illegal();
    test_timeout();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
